// File: rtl/tsensor_pkg.sv
// Shared types and constants for the timing-sensor alarm monitor.
// Holds the FSM state encoding and the default sensor/count widths.
package tsensor_pkg;

    localparam int N_SENS_DEF = 32;
    localparam int CNT6_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALERT = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

endpackage

// File: rtl/popcount32.sv
// Purely combinational 32-bit population count.
// Ports: din[31:0] in, cnt[5:0] out (0..32).
module popcount32
    import tsensor_pkg::*;
(
    input  logic [31:0]       din,
    output logic [CNT6_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {{(CNT6_W-1){1'b0}}, din[i]};
        end
    end

endmodule

// File: rtl/tsensor_alarm_monitor.sv
// Aggregates timing-sensor alarm lines into an interrupt with cooldown.
// Ports: clk, rst (sync, active-high), alarm/mask[N_SENS], thresh[6],
//        ack, clear in; irq, sticky[N_SENS], peak[6], event_cnt[CNT_W],
//        state[2] out.
module tsensor_alarm_monitor
    import tsensor_pkg::*;
#(
    parameter int N_SENS    = N_SENS_DEF,
    parameter int QUIET_CYC = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SENS-1:0] alarm,
    input  logic [N_SENS-1:0] mask,
    input  logic [5:0]        thresh,
    input  logic              ack,
    input  logic              clear,
    output logic              irq,
    output logic [N_SENS-1:0] sticky,
    output logic [5:0]        peak,
    output logic [CNT_W-1:0]  event_cnt,
    output logic [1:0]        state
);

    localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

    logic [N_SENS-1:0] alarm_q;
    logic [N_SENS-1:0] masked;
    logic [31:0]       pc_in;
    logic [5:0]        pc_out;
    logic [5:0]        cnt_q;
    logic              hit;

    state_t            state_q;
    state_t            state_d;
    logic [QW-1:0]     quiet_q;
    logic [QW-1:0]     quiet_d;

    assign masked = alarm_q & mask;
    // Narrower arrays are zero-extended into the fixed 32-bit counter.
    assign pc_in  = 32'(masked);

    popcount32 u_pc (
        .din (pc_in),
        .cnt (pc_out)
    );

    assign hit = (thresh != 6'd0) && (cnt_q >= thresh);

    // Two-stage pipeline: raw alarms, then masked count.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= '0;
            cnt_q   <= '0;
        end else begin
            alarm_q <= alarm;
            cnt_q   <= pc_out;
        end
    end

    // Statistics; clear wins over same-edge contributions.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sticky    <= '0;
            peak      <= '0;
            event_cnt <= '0;
        end else begin
            sticky <= sticky | masked;
            if (cnt_q > peak) begin
                peak <= cnt_q;
            end
            if (hit && (event_cnt != '1)) begin
                event_cnt <= event_cnt + 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            quiet_q <= '0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_ALERT;
                end
            end
            ST_ALERT: begin
                if (ack) begin
                    state_d = ST_COOL;
                    quiet_d = '0;
                end
            end
            ST_COOL: begin
                if (hit) begin
                    quiet_d = '0;
                end else if (quiet_q == QUIET_LAST) begin
                    state_d = ST_IDLE;
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                quiet_d = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        irq   = (state_q == ST_ALERT);
        state = state_q;
    end

endmodule

// File: tb/tb_tsensor_alarm_monitor.sv
// Scoreboard bench for tsensor_alarm_monitor.
// Stimulus queues expected values; a negedge monitor pops and compares.
module tb_tsensor_alarm_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alarm;
    logic [31:0] mask;
    logic [5:0]  thresh;
    logic        ack;
    logic        clear;
    logic        irq;
    logic [31:0] sticky;
    logic [5:0]  peak;
    logic [15:0] event_cnt;
    logic [1:0]  state;

    tsensor_alarm_monitor #(
        .N_SENS    (32),
        .QUIET_CYC (16),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alarm     (alarm),
        .mask      (mask),
        .thresh    (thresh),
        .ack       (ack),
        .clear     (clear),
        .irq       (irq),
        .sticky    (sticky),
        .peak      (peak),
        .event_cnt (event_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    localparam int K_IRQ = 0;
    localparam int K_STK = 1;
    localparam int K_PK  = 2;
    localparam int K_EV  = 3;
    localparam int K_ST  = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int kind);
        case (kind)
            K_IRQ:   return {31'd0, irq};
            K_STK:   return sticky;
            K_PK:    return {26'd0, peak};
            K_EV:    return {16'd0, event_cnt};
            default: return {30'd0, state};
        endcase
    endfunction

    task automatic chk(int kind, logic [31:0] val, string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    exp_t        me;
    logic [31:0] act;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me  = q.pop_front();
            act = actual(me.kind);
            n_total++;
            if (me.cyc != cyc) begin
                $display("FAIL %s: stale check, got %h want %h",
                         me.name, act, me.val);
            end else if (act === me.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %h want %h", me.name, act, me.val);
            end
        end
    end

    initial begin
        rst = 1'b1; alarm = '0; mask = '0; thresh = '0;
        ack = 1'b0; clear = 1'b0;
        step(2);
        chk(K_IRQ, 0, "rst_irq");
        chk(K_ST,  0, "rst_state");
        chk(K_STK, 0, "rst_sticky");
        chk(K_PK,  0, "rst_peak");
        chk(K_EV,  0, "rst_ev");
        rst = 1'b0;

        // single-cycle two-bit alarm at threshold 2
        mask = 32'hFFFF_FFFF; thresh = 6'd2; alarm = 32'h3;
        step(1);
        alarm = '0;
        chk(K_IRQ, 0, "t1_e0_irq");
        step(1);
        chk(K_IRQ, 0, "t1_e1_irq");
        chk(K_STK, 32'h3, "t1_sticky");
        step(1);
        chk(K_IRQ, 1, "t1_e2_irq");
        chk(K_ST,  1, "t1_state");
        chk(K_EV,  1, "t1_ev");
        chk(K_PK,  2, "t1_peak");
        step(3);
        chk(K_ST, 1, "t1_hold_alert");
        chk(K_EV, 1, "t1_ev_hold");

        // ack, hit at cooldown cycle 10, then 16 quiet edges
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk(K_ST,  2, "cd_enter");
        chk(K_IRQ, 0, "cd_irq0");
        step(7);
        alarm = 32'h3;
        step(1);
        alarm = '0;
        step(2);
        chk(K_ST,  2, "cd_hit_state");
        chk(K_IRQ, 0, "cd_hit_irq");
        step(15);
        chk(K_ST,  2, "cd_q15_state");
        chk(K_IRQ, 0, "cd_q15_irq");
        step(1);
        chk(K_ST,  0, "cd_exit_state");
        chk(K_IRQ, 0, "cd_exit_irq");
        chk(K_EV,  2, "cd_ev");

        // ack outside ALERT
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk(K_ST, 0, "ack_idle");
        step(1);
        chk(K_ST, 0, "ack_idle2");

        // clear while alarm_q holds 0x10
        alarm = 32'h10;
        step(1);
        clear = 1'b1; alarm = 32'h20;
        step(1);
        clear = 1'b0; alarm = '0;
        chk(K_STK, 0, "clr_sticky");
        chk(K_EV,  0, "clr_ev");
        chk(K_PK,  0, "clr_peak");
        step(1);
        chk(K_STK, 32'h20, "clr_next_sticky");
        chk(K_PK,  1, "clr_next_peak");
        step(1);
        chk(K_ST, 0, "clr_state");
        step(2);

        // masked-out alarms
        clear = 1'b1; mask = 32'h0000_FFFF; thresh = 6'd1;
        alarm = 32'hFFFF_0000;
        step(1);
        clear = 1'b0;
        step(4);
        chk(K_IRQ, 0, "msk_irq");
        chk(K_STK, 0, "msk_sticky");
        chk(K_EV,  0, "msk_ev");
        chk(K_PK,  0, "msk_peak");

        // mask change takes effect next edge; sticky persists
        mask = 32'hFFFF_FFFF;
        step(1);
        chk(K_STK, 32'hFFFF_0000, "mch_sticky");
        chk(K_IRQ, 0, "mch_irq0");
        step(1);
        chk(K_IRQ, 1, "mch_irq1");
        chk(K_EV,  1, "mch_ev1");
        chk(K_PK,  16, "mch_peak");
        mask = 32'h0000_FFFF;
        step(2);
        chk(K_STK, 32'hFFFF_0000, "mch_sticky_keep");
        chk(K_EV,  2, "mch_ev2");
        chk(K_ST,  1, "mch_state");

        // reset mid-ALERT with alarm held
        mask = 32'hFFFF_FFFF; rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk(K_IRQ, 0, "rsa_irq");
        chk(K_ST,  0, "rsa_state");
        chk(K_STK, 0, "rsa_sticky");
        chk(K_EV,  0, "rsa_ev");
        step(1);
        chk(K_IRQ, 0, "rsa_r1_irq");
        step(1);
        chk(K_IRQ, 0, "rsa_r2_irq");
        chk(K_EV,  0, "rsa_r2_ev");
        step(1);
        chk(K_IRQ, 1, "rsa_r3_irq");
        chk(K_EV,  1, "rsa_r3_ev");

        // saturation
        clear = 1'b1; thresh = 6'd1; alarm = 32'hFFFF_FFFF;
        step(1);
        clear = 1'b0;
        step(70000);
        chk(K_EV,  32'hFFFF, "sat_ev");
        chk(K_PK,  32, "sat_peak");
        chk(K_STK, 32'hFFFF_FFFF, "sat_sticky");
        chk(K_ST,  1, "sat_state");

        // continuous hits hold COOLDOWN; thresh=0 disables detection
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(20);
        chk(K_ST,  2, "hold_cd_state");
        chk(K_IRQ, 0, "hold_cd_irq");
        thresh = 6'd0;
        step(15);
        chk(K_ST, 2, "th0_q15");
        step(1);
        chk(K_ST, 0, "th0_idle");
        chk(K_EV, 32'hFFFF, "th0_ev");
        step(3);
        chk(K_ST,  0, "th0_stay");
        chk(K_IRQ, 0, "th0_irq");

        step(2);
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", q.size());
            n_total++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tsensor_alarm_monitor.md
TSENSOR_ALARM_MONITOR -- requirements
Module: tsensor_alarm_monitor

Interface
REQ-001 The block SHALL have parameter N_SENS, default 32, giving the number of sensor alarm lines.
REQ-002 The block SHALL have parameter QUIET_CYC, default 16, giving the number of consecutive no-hit cycles needed to leave COOLDOWN.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the event counter width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock, same domain as the sensor array.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 alarm  input  N_SENS  per-sensor alarm bits from the timing-sensor array.
REQ-008 mask  input  N_SENS  per-sensor enable; 1 = sensor participates.
REQ-009 thresh  input  6  minimum simultaneous masked alarms that constitute a hit; 0 = detection disabled.
REQ-010 ack  input  1  software acknowledge of the interrupt; single-cycle pulse.
REQ-011 clear  input  1  clears sticky, peak and event_cnt; single-cycle pulse.
REQ-012 irq  output  1  interrupt; high in the ALERT state only.
REQ-013 sticky  output  N_SENS  accumulated OR of masked alarms since the last clear.
REQ-014 peak  output  6  maximum masked alarm count seen since the last clear.
REQ-015 event_cnt  output  CNT_W  number of hit cycles since the last clear; saturating.
REQ-016 state  output  2  current FSM state encoding, for debug.

Function
REQ-017 Pipeline stage 1 SHALL register alarm into alarm_q on every edge.
REQ-018 Stage 2 SHALL register cnt_q = popcount(alarm_q & mask), 6 bits wide, range 0..32.
REQ-019 hit SHALL be (thresh != 0) && (cnt_q >= thresh); this is a combinational signal from stage 2.
REQ-020 An alarm present before edge E0 SHALL yield cnt_q valid after E1 and an FSM reaction at E2; irq SHALL be high after E2 (3-edge latency).
REQ-021 sticky SHALL update at each edge as sticky | (alarm_q & mask).
REQ-022 peak SHALL update to cnt_q whenever cnt_q > peak.
REQ-023 event_cnt SHALL increment by 1 on each edge where hit is high, and hold at all-ones when saturated.
REQ-024 The FSM SHALL have three states: IDLE=0, ALERT=1, COOLDOWN=2.
REQ-025 In IDLE, hit SHALL move the FSM to ALERT.
REQ-026 In ALERT, ack SHALL move the FSM to COOLDOWN and load quiet_cnt with 0; the FSM SHALL remain in ALERT until ack.
REQ-027 In COOLDOWN, hit SHALL reset quiet_cnt to 0 and keep the FSM in COOLDOWN; no re-assertion of irq occurs there.
REQ-028 In COOLDOWN, no-hit SHALL increment quiet_cnt; when quiet_cnt reaches QUIET_CYC-1 with no hit, the FSM SHALL move to IDLE.
REQ-029 ack outside ALERT SHALL be ignored.
REQ-030 clear SHALL take priority over simultaneous updates: sticky, peak and event_cnt become 0 at that edge, and same-edge alarm contributions are dropped.
REQ-031 clear SHALL NOT affect the FSM, irq or the pipeline registers.
REQ-032 A mask change SHALL take effect on the cnt_q computed at the next edge; already-set sticky bits SHALL remain set.
REQ-033 Unused state encoding 3 SHALL return the FSM to IDLE on the next edge.

Reset
REQ-034 On rst, alarm_q, cnt_q, sticky, peak, event_cnt and quiet_cnt SHALL all be set to 0.
REQ-035 On rst, the FSM SHALL go to IDLE and irq SHALL be 0.
REQ-036 rst asserted mid-ALERT or mid-COOLDOWN SHALL abort to IDLE with no pending interrupt.
REQ-037 During the first 2 edges after reset release, hit SHALL be low because the pipeline holds zeros.

Structure
REQ-038 A shared package tsensor_pkg SHALL hold the FSM state typedef, N_SENS_DEF=32 and the count width constant 6.
REQ-039 There SHALL be one sub-module, popcount32, a purely combinational 32-to-6 population count instantiated in stage 2.
REQ-040 All remaining logic SHALL be in tsensor_alarm_monitor.

Verification
REQ-041 mask=FFFFFFFF, thresh=2, alarm=00000003 for 1 cycle -> irq=1 after the 3rd edge; event_cnt=1; sticky=00000003; peak=2.
REQ-042 mask=0000FFFF, thresh=1, alarm=FFFF0000 held -> irq stays 0; sticky=0; event_cnt=0.
REQ-043 In ALERT, ack pulse, then alarm hit at cooldown cycle 10, then quiet -> FSM leaves COOLDOWN exactly QUIET_CYC=16 no-hit cycles after the hit; irq stays 0 throughout.
REQ-044 alarm=FFFFFFFF, thresh=1, held 70000 cycles -> event_cnt saturates at FFFF; peak=32.
REQ-045 clear on the same edge as a new alarm=00000010 -> sticky=0, event_cnt=0; the next-cycle alarm is recorded normally.
REQ-046 rst in ALERT with alarm held -> irq=0 immediately after the reset edge; irq re-asserts 3 edges after rst release.
